traffic_timer: RTL and testbench
================================

# traffic_timer

Front-end stage for the traffic-light controllers. It conditions the raw vehicle-loop sensor into a latched request `s`. It also generates the green and yellow downcounts `g_dc`/`y_dc` that the light FSM consumes. The lamp outputs `g`/`y` are fed back from the downstream FSM so each countdown starts and runs only during its own phase.

## Interface
Parameters:
- `TICK_DIV`, default 1000: clock cycles per countdown step, legal range ≥1.
- `DEB_CYCLES`, default 4: consecutive stable synchronized samples required to change the debounced sensor, legal range ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sensor_raw`  in  1  raw loop detector, asynchronous to `clk`, may bounce.
- `g`  in  1  green lamp fed back from the light FSM.
- `y`  in  1  yellow lamp fed back from the light FSM.
- `green_len`  in  16  green duration in ticks.
- `yellow_len`  in  16  yellow duration in ticks.
- `s`  out  1  latched vehicle request, goes to the FSM sensor input.
- `g_dc`  out  16  green downcount, registered.
- `y_dc`  out  16  yellow downcount, registered.

## Operation
- **Synchronizer:** a 2-flop chain `q1`→`q2` on `sensor_raw`.
- **Debouncer:**
  - State is `db` (1 bit) plus counter `cnt`.
  - If `q2==db`, then `cnt<=0`.
  - Otherwise, if `cnt==DEB_CYCLES-1`, then `db<=q2` and `cnt<=0`; else `cnt<=cnt+1`.
- **Request latch `req`:** drives `s` directly.
  - Cleared on every edge where `g==1`. Clear has priority, so arrivals during green are dropped.
  - Otherwise set on the edge where `db` flips 0→1.
  - Otherwise holds, so `s` stays high after the car leaves, until green.
- **Phase tracking:**
  - `ph_prev` registers `{g,y}` each edge.
  - `phase_chg = ({g,y} != ph_prev)`.
- **Prescaler `pc`:**
  - `pc<=0` when `phase_chg`.
  - Else `pc<=0` when `pc==TICK_DIV-1`.
  - Else `pc<=pc+1`.
  - `tick = !phase_chg && pc==TICK_DIV-1`. With `TICK_DIV==1`, tick is every non-phase-change cycle.
- **Green counter:**
  - While `g==0`: `g_dc<=green_len` every edge (continuous reload).
  - While `g==1`: `g_dc<=g_dc-1` on tick if `g_dc!=0`. It saturates at 0 and never wraps.
  - `green_len` changes during green are ignored.
- **Yellow counter:** identical, using `y`, `y_dc` and `yellow_len`.
  - `y_dc` is reloaded throughout red and green, so it is valid on yellow entry.
- **Illegal lamp combinations:** if `g` and `y` are both 1, each counter follows its own rule independently. No error detection.
- **Arithmetic:** unsigned 16-bit throughout. `pc` width is `$clog2(TICK_DIV)` with a minimum of 1; `cnt` width is `$clog2(DEB_CYCLES)` with a minimum of 1.

## Timing
- **Reset (async, while `rst_n==0`):**
  - `s=0`, `g_dc=0`, `y_dc=0`.
  - `q1`, `q2`, `db`, `cnt`, `pc` are 0; `ph_prev=2'b00`.
- **Reset release:** first edge with `g==0` reloads `g_dc`. Sensor latency (below) guarantees the reload precedes any green.
- **Sensor latency:**
  - Condition: `sensor_raw` high and stable from before edge 1.
  - `q2` is high after edge 2, `db` and `s` are high after edge `2+DEB_CYCLES` (edge 6 at default).
  - Falling `db` is delayed the same amount but does not clear `s`.
- **Green phase timing:** green entered at edge E, meaning `g` is high after E.
  - `phase_chg` at E+1 clears `pc`; no decrement there.
  - Decrements occur at E+1+k·TICK_DIV for k=1..`green_len`.
  - `g_dc` reaches 0 after E+1+`green_len`·TICK_DIV.
  - The FSM leaves green at the next edge, so green lasts `green_len`·TICK_DIV+2 cycles.
- **Yellow phase timing:** same formula with `yellow_len`.
- **`green_len==0`:** `g_dc` is 0 on entry; the FSM leaves after 1 cycle.
- **`s` clear:** `s` falls one edge after `g` rises (edge E+1).
- **Reset mid-operation:** outputs go to reset values immediately and asynchronously; no partial-phase state survives.

## Test plan
- **Debounce:**
  - Stimulus: `DEB_CYCLES=4`, `sensor_raw` 0→1 held.
  - Required: `s` rises after edge 6.
  - Stimulus: a 3-cycle high pulse, or 1/0 chatter every 2 cycles.
  - Required: `s` stays 0.
- **Request latch:**
  - Stimulus: `sensor_raw` high for 10 cycles then low, `g=0`.
  - Required: `s` stays 1.
  - Stimulus: drive `g=1` at edge E.
  - Required: `s=0` after E+1. A new sensor rise while `g=1` leaves `s=0`.
- **Green countdown:**
  - Stimulus: `TICK_DIV=1`, `green_len=3`, `g` raised at E.
  - Required: `g_dc` after E..E+4 = 3,3,2,1,0, then holds at 0.
  - Required (with `traffic_light1` in loop): green lasts 5 cycles.
- **Yellow with prescaler:**
  - Stimulus: `TICK_DIV=4`, `yellow_len=2`, `y` raised at E.
  - Required: `y_dc` 2→1 at E+5 and 1→0 at E+9; yellow lasts 10 cycles.
  - Required: changing `yellow_len` to 7 mid-yellow has no effect.
- **Zero length:**
  - Stimulus: `green_len=0`.
  - Required: `g_dc==0` on green entry; the FSM goes to yellow after 1 green cycle.
- **Async reset:**
  - Stimulus: `rst_n` pulled low mid-green, between clock edges, with `g_dc=5`.
  - Required: `g_dc`, `y_dc` and `s` read 0 before the next edge.
  - Required: after release with `g=0`, `g_dc` reloads `green_len` on the first edge.

Source files
------------

// File: rtl/traffic_timer.sv
// Sensor conditioning (sync, debounce, request latch) and the green/yellow
// downcounters for the light FSM; lamp feedback gates each countdown.
module traffic_timer #(
  parameter int TICK_DIV   = 1000,
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sensor_raw,
  input  logic        g,
  input  logic        y,
  input  logic [15:0] green_len,
  input  logic [15:0] yellow_len,
  output logic        s,
  output logic [15:0] g_dc,
  output logic [15:0] y_dc
);

  localparam int PC_W  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             q1_q, q2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic [1:0]       ph_prev_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      g_dc_q, g_dc_d;
  logic [15:0]      y_dc_q, y_dc_d;

  logic phase_chg;
  logic pc_wrap;
  logic tick;
  logic db_rise;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (q2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = q2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Set on the very edge db goes high, so the request appears with db itself.
  assign db_rise = db_d & ~db_q;

  always_comb begin
    req_d = req_q;
    if (g) begin
      req_d = 1'b0;
    end else if (db_rise) begin
      req_d = 1'b1;
    end
  end

  assign phase_chg = ({g, y} != ph_prev_q);
  assign pc_wrap   = (pc_q == PC_MAX);
  assign tick      = !phase_chg && pc_wrap;

  always_comb begin
    pc_d = pc_q + 1'b1;
    if (phase_chg || pc_wrap) begin
      pc_d = '0;
    end
  end

  // Counters reload continuously outside their phase and saturate at zero inside it.
  always_comb begin
    g_dc_d = g_dc_q;
    if (!g) begin
      g_dc_d = green_len;
    end else if (tick && (g_dc_q != 16'd0)) begin
      g_dc_d = g_dc_q - 16'd1;
    end
  end

  always_comb begin
    y_dc_d = y_dc_q;
    if (!y) begin
      y_dc_d = yellow_len;
    end else if (tick && (y_dc_q != 16'd0)) begin
      y_dc_d = y_dc_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q      <= 1'b0;
      q2_q      <= 1'b0;
      db_q      <= 1'b0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      ph_prev_q <= 2'b00;
      pc_q      <= '0;
      g_dc_q    <= 16'd0;
      y_dc_q    <= 16'd0;
    end else begin
      q1_q      <= sensor_raw;
      q2_q      <= q1_q;
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      ph_prev_q <= {g, y};
      pc_q      <= pc_d;
      g_dc_q    <= g_dc_d;
      y_dc_q    <= y_dc_d;
    end
  end

  assign s    = req_q;
  assign g_dc = g_dc_q;
  assign y_dc = y_dc_q;

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer: one instance with TICK_DIV=1 and one with
// TICK_DIV=4 share the same stimulus.
module tb_traffic_timer;

  logic        clk;
  logic        rst_n;
  logic        sensor_raw;
  logic        g;
  logic        y;
  logic [15:0] green_len;
  logic [15:0] yellow_len;
  logic        s1, s4;
  logic [15:0] gdc1, ydc1, gdc4, ydc4;

  int checks = 0;
  int errors = 0;

  traffic_timer #(.TICK_DIV(1), .DEB_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .sensor_raw(sensor_raw), .g(g), .y(y),
    .green_len(green_len), .yellow_len(yellow_len),
    .s(s1), .g_dc(gdc1), .y_dc(ydc1)
  );

  traffic_timer #(.TICK_DIV(4), .DEB_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sensor_raw(sensor_raw), .g(g), .y(y),
    .green_len(green_len), .yellow_len(yellow_len),
    .s(s4), .g_dc(gdc4), .y_dc(ydc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] e1, e4;
    rst_n      = 1'b0;
    sensor_raw = 1'b0;
    g          = 1'b0;
    y          = 1'b0;
    green_len  = 16'd3;
    yellow_len = 16'd2;

    // Reset values
    #3;
    chk("rst_s1", 16'(s1), 16'd0);
    chk("rst_gdc1", gdc1, 16'd0);
    chk("rst_ydc1", ydc1, 16'd0);
    chk("rst_s4", 16'(s4), 16'd0);
    chk("rst_gdc4", gdc4, 16'd0);
    chk("rst_ydc4", ydc4, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First edge after release reloads both counters
    step();
    chk("reload_gdc1", gdc1, 16'd3);
    chk("reload_ydc1", ydc1, 16'd2);
    chk("reload_gdc4", gdc4, 16'd3);

    // 3-cycle pulse is rejected
    sensor_raw = 1'b1;
    repeat (3) step();
    sensor_raw = 1'b0;
    repeat (8) step();
    chk("pulse_s1", 16'(s1), 16'd0);
    chk("pulse_s4", 16'(s4), 16'd0);

    // Chatter every 2 cycles is rejected
    for (int i = 0; i < 8; i++) begin
      sensor_raw = ~sensor_raw;
      repeat (2) step();
    end
    repeat (8) step();
    chk("chatter_s1", 16'(s1), 16'd0);

    // Stable rise: s high after edge 6
    sensor_raw = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("deb_s1_e%0d", k), 16'(s1), (k == 6) ? 16'd1 : 16'd0);
    end
    chk("deb_s4_e6", 16'(s4), 16'd1);

    // Request holds after the car leaves
    repeat (4) step();
    sensor_raw = 1'b0;
    repeat (10) step();
    chk("hold_s1", 16'(s1), 16'd1);
    chk("hold_s4", 16'(s4), 16'd1);

    // Green countdown; s clears at E+1, sensor rise during green dropped
    chk("green_pre_gdc1", gdc1, 16'd3);
    g = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      e1 = (k <= 1) ? 16'd3 : (k == 2) ? 16'd2 : (k == 3) ? 16'd1 : 16'd0;
      e4 = (k < 5) ? 16'd3 : (k < 9) ? 16'd2 : 16'd1;
      chk($sformatf("green_gdc1_k%0d", k), gdc1, e1);
      chk($sformatf("green_gdc4_k%0d", k), gdc4, e4);
      if (k == 1) begin
        chk("green_sclr_s1", 16'(s1), 16'd0);
        sensor_raw = 1'b1;
      end
    end
    chk("green_drop_s1", 16'(s1), 16'd0);
    chk("green_drop_s4", 16'(s4), 16'd0);
    g = 1'b0;
    sensor_raw = 1'b0;
    step();
    chk("green_exit_gdc1", gdc1, 16'd3);

    // Yellow with prescaler; mid-yellow length change ignored
    chk("yellow_pre_ydc4", ydc4, 16'd2);
    y = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      e4 = (k < 5) ? 16'd2 : (k < 9) ? 16'd1 : 16'd0;
      e1 = (k == 1) ? 16'd2 : (k == 2) ? 16'd1 : 16'd0;
      chk($sformatf("yellow_ydc4_k%0d", k), ydc4, e4);
      chk($sformatf("yellow_ydc1_k%0d", k), ydc1, e1);
      if (k == 3) yellow_len = 16'd7;
    end
    y = 1'b0;
    step();
    chk("yellow_exit_ydc4", ydc4, 16'd7);
    chk("yellow_exit_ydc1", ydc1, 16'd7);

    // Zero-length green
    green_len = 16'd0;
    step();
    g = 1'b1;
    step();
    chk("zero_gdc1", gdc1, 16'd0);
    chk("zero_gdc4", gdc4, 16'd0);
    step();
    chk("zero_hold_gdc1", gdc1, 16'd0);
    g = 1'b0;

    // Asynchronous reset mid-green
    green_len = 16'd5;
    step();
    chk("ar_pre_gdc1", gdc1, 16'd5);
    g = 1'b1;
    step();
    chk("ar_green_gdc1", gdc1, 16'd5);
    chk("ar_green_gdc4", gdc4, 16'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gdc1", gdc1, 16'd0);
    chk("ar_ydc1", ydc1, 16'd0);
    chk("ar_s1", 16'(s1), 16'd0);
    chk("ar_gdc4", gdc4, 16'd0);
    chk("ar_ydc4", ydc4, 16'd0);
    g = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_reload_gdc1", gdc1, 16'd5);
    chk("ar_reload_gdc4", gdc4, 16'd5);
    chk("ar_reload_ydc1", ydc1, 16'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
